// File: rtl/keypad_pkg.sv
// Shared keypad definitions: FSM state codes, keycode field positions and bounce LFSR.
// The scanner uses the same keycode field positions.
package keypad_pkg;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_PRESS = 2'd1;
  localparam state_t ST_HELD  = 2'd2;
  localparam state_t ST_REL   = 2'd3;

  localparam int ROW_MSB = 3;
  localparam int ROW_LSB = 2;
  localparam int COL_MSB = 1;
  localparam int COL_LSB = 0;

  // x^8+x^6+x^5+x^4+1, feedback shifted in at bit 0
  localparam logic [7:0] LFSR_TAPS         = 8'hB8;
  localparam logic [7:0] LFSR_SEED_DEFAULT = 8'hA5;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR used to generate contact-bounce noise.
module lfsr8
  import keypad_pkg::*;
#(
  parameter logic [7:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  output logic [7:0] state
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       state <= SEED;
    else if (enable) state <= lfsr_next(state);
  end

endmodule

// File: rtl/keypad_emulator.sv
// Emulates one matrix-keypad switch with bounce: answers a scanner's column
// drive on the latched key's row while the emulated contact is closed.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int         BOUNCE_CYCLES = 16,
  parameter logic [7:0] LFSR_SEED     = LFSR_SEED_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  col,
  input  logic        press_req,
  input  logic [3:0]  keycode_in,
  input  logic [15:0] hold_cycles,
  output logic [3:0]  row,
  output logic        contact,
  output logic        busy,
  output logic        done
);

  localparam bit          NOBOUNCE = (BOUNCE_CYCLES == 0);
  localparam logic [15:0] BLOAD    = NOBOUNCE ? 16'd0 : 16'(BOUNCE_CYCLES - 1);

  state_t      state, nxt;
  logic [15:0] bcnt, hcnt;
  logic [3:0]  key;
  logic [7:0]  lfsr;
  logic        bouncing, accept, nbit;

  assign bouncing = (state == ST_PRESS) || (state == ST_REL);
  assign accept   = (state == ST_IDLE) && press_req;
  assign busy     = (state != ST_IDLE);
  // contact is registered, so it must see the LFSR value of the cycle it will be shown in
  assign nbit     = bouncing ? ^(lfsr & LFSR_TAPS) : lfsr[0];

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clock  (clock),
    .reset  (reset),
    .enable (bouncing),
    .state  (lfsr)
  );

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (press_req)  nxt = NOBOUNCE ? ST_HELD : ST_PRESS;
      ST_PRESS: if (bcnt == '0) nxt = ST_HELD;
      ST_HELD:  if (hcnt == '0) nxt = NOBOUNCE ? ST_IDLE : ST_REL;
      ST_REL:   if (bcnt == '0) nxt = ST_IDLE;
      default:                  nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      contact <= 1'b0;
      done    <= 1'b0;
      bcnt    <= '0;
      hcnt    <= '0;
      key     <= '0;
    end else begin
      state <= nxt;
      done  <= (state != ST_IDLE) && (nxt == ST_IDLE);
      case (nxt)
        ST_HELD:         contact <= 1'b1;
        ST_PRESS, ST_REL: contact <= nbit;
        default:         contact <= 1'b0;
      endcase
      // hold of zero still gives one closed cycle
      if (accept) begin
        key  <= keycode_in;
        hcnt <= (hold_cycles == '0) ? 16'd0 : hold_cycles - 16'd1;
      end else if (state == ST_HELD && hcnt != '0) begin
        hcnt <= hcnt - 16'd1;
      end
      if ((nxt == ST_PRESS || nxt == ST_REL) && nxt != state) bcnt <= BLOAD;
      else if (bouncing && bcnt != '0)                       bcnt <= bcnt - 16'd1;
    end
  end

  always_comb begin
    row = 4'hF;
    if (contact && !col[key[COL_MSB:COL_LSB]]) row[key[ROW_MSB:ROW_LSB]] = 1'b0;
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: default-bounce and zero-bounce instances driven by
// directed and random presses, checked against a per-cycle contact/row model.
module tb_keypad_emulator;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  col, keycode_in;
  logic [15:0] hold_cycles;
  logic        pr_a, pr_b;
  logic [3:0]  row_a, row_b;
  logic        contact_a, contact_b, busy_a, busy_b, done_a, done_b;

  always #5 clock = ~clock;

  keypad_emulator dut_a (
    .clock(clock), .reset(reset), .col(col), .press_req(pr_a),
    .keycode_in(keycode_in), .hold_cycles(hold_cycles),
    .row(row_a), .contact(contact_a), .busy(busy_a), .done(done_a)
  );

  keypad_emulator #(.BOUNCE_CYCLES(0)) dut_b (
    .clock(clock), .reset(reset), .col(col), .press_req(pr_b),
    .keycode_in(keycode_in), .hold_cycles(hold_cycles),
    .row(row_b), .contact(contact_b), .busy(busy_b), .done(done_b)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_lfsr = 8'hA5;
  int         n_busy, n_low, n_r3, n_c;
  logic [3:0] det;
  logic       det_v;

  // bounce source: polynomial x^8+x^6+x^5+x^4+1, new bit enters at the bottom
  function automatic logic [7:0] ref_step(input logic [7:0] v);
    logic fb;
    fb = v[7] ^ v[5] ^ v[4] ^ v[3];
    return {v[6:0], fb};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts at posedge+1; request is accepted on the next edge. Returns at posedge+1.
  task automatic press(input bit sel, input logic [3:0] k, input logic [15:0] h,
                       input int restrobe, input int colmode, input int abort_at);
    int         b, hh, tot;
    logic       exp_c, aborted;
    logic [3:0] exp_row, one, rw;
    b  = sel ? 0 : 16;
    hh = (h == 16'd0) ? 1 : int'(h);
    tot = 2 * b + hh;
    n_busy = 0; n_low = 0; n_r3 = 0; n_c = 0; det = 4'h0; det_v = 1'b0; aborted = 1'b0;
    one = 4'b0001;
    keycode_in = k; hold_cycles = h;
    if (sel) pr_b = 1'b1; else pr_a = 1'b1;
    @(posedge clock); #1;
    pr_a = 1'b0; pr_b = 1'b0;
    keycode_in = 4'($urandom); hold_cycles = 16'($urandom);
    for (int i = 0; i < tot && !aborted; i++) begin
      if (i < b || i >= b + hh) begin
        exp_c = m_lfsr[0];
        if (!sel) m_lfsr = ref_step(m_lfsr);
      end else exp_c = 1'b1;
      case (colmode)
        0:       col = 4'($urandom);
        1:       col = ~(one << (i % 4));
        default: col = 4'b1011;
      endcase
      if (i == restrobe) begin
        keycode_in = 4'hF; hold_cycles = 16'd3;
        if (sel) pr_b = 1'b1; else pr_a = 1'b1;
      end else begin
        pr_a = 1'b0; pr_b = 1'b0;
      end
      if (i == abort_at) begin
        col = 4'h0; reset = 1'b1; #1;
        chk("abort_contact", 32'(sel ? contact_b : contact_a), 32'(0));
        chk("abort_row",     32'(sel ? row_b : row_a), 32'hF);
        chk("abort_busy",    32'(sel ? busy_b : busy_a), 32'(0));
        m_lfsr = 8'hA5;
        @(negedge clock);
        chk("abort_done", 32'(sel ? done_b : done_a), 32'(0));
        @(posedge clock); #1; reset = 1'b0;
        repeat (3) begin
          @(negedge clock);
          chk("post_abort_done", 32'(sel ? done_b : done_a), 32'(0));
          chk("post_abort_busy", 32'(sel ? busy_b : busy_a), 32'(0));
          @(posedge clock); #1;
        end
        aborted = 1'b1;
      end else begin
        exp_row = 4'hF;
        if (exp_c && !col[k[1:0]]) exp_row[k[3:2]] = 1'b0;
        @(negedge clock);
        rw = sel ? row_b : row_a;
        chk("contact", 32'(sel ? contact_b : contact_a), 32'(exp_c));
        chk("row",     32'(rw), 32'(exp_row));
        chk("busy",    32'(sel ? busy_b : busy_a), 32'(1));
        chk("done_early", 32'(sel ? done_b : done_a), 32'(0));
        if (sel ? busy_b : busy_a) n_busy++;
        if (sel ? contact_b : contact_a) n_c++;
        if (!rw[k[3:2]]) n_low++;
        if (!rw[3]) n_r3++;
        if (rw != 4'hF) begin
          det_v = 1'b1;
          for (int r = 0; r < 4; r++) if (!rw[r]) det[3:2] = 2'(r);
          for (int c = 0; c < 4; c++) if (!col[c]) det[1:0] = 2'(c);
        end
        @(posedge clock); #1;
      end
    end
    pr_a = 1'b0; pr_b = 1'b0;
    if (!aborted) begin
      @(negedge clock);
      chk("done_pulse", 32'(sel ? done_b : done_a), 32'(1));
      chk("idle_busy",  32'(sel ? busy_b : busy_a), 32'(0));
      chk("idle_contact", 32'(sel ? contact_b : contact_a), 32'(0));
      @(posedge clock); #1;
      @(negedge clock);
      chk("done_single", 32'(sel ? done_b : done_a), 32'(0));
      @(posedge clock); #1;
    end
  endtask

  initial begin
    reset = 1'b1; col = 4'hF; pr_a = 1'b0; pr_b = 1'b0;
    keycode_in = 4'h0; hold_cycles = 16'h0;
    repeat (3) @(posedge clock);
    #1 col = 4'h0;
    @(negedge clock);
    chk("rst_row_a", 32'(row_a), 32'hF);
    chk("rst_row_b", 32'(row_b), 32'hF);
    chk("rst_contact_a", 32'(contact_a), 32'(0));
    chk("rst_busy_a", 32'(busy_a), 32'(0));
    chk("rst_done_a", 32'(done_a), 32'(0));
    chk("rst_busy_b", 32'(busy_b), 32'(0));
    @(posedge clock); #1;
    reset = 1'b0;

    // first edge after reset release accepts; key row1/col2 with that column held low
    press(1'b1, 4'b0110, 16'd5, -1, 2, -1);
    chk("nb_low_cycles", 32'(n_low), 32'(5));
    chk("nb_busy_cycles", 32'(n_busy), 32'(5));

    press(1'b0, 4'($urandom), 16'd10, -1, 0, -1);
    chk("default_busy_cycles", 32'(n_busy), 32'(42));

    press(1'b0, 4'h0, 16'd8, 2, 1, -1);
    chk("restrobe_row3", 32'(n_r3), 32'(0));

    press(1'b1, 4'($urandom), 16'd0, -1, 0, -1);
    chk("hold0_contact_cycles", 32'(n_c), 32'(1));

    for (int n = 0; n < 10; n++)
      press(1'($urandom), 4'($urandom), 16'($urandom_range(0, 19)),
            ($urandom_range(0, 3) == 0) ? 1 : -1, int'($urandom_range(0, 1)), -1);

    press(1'b0, 4'h5, 16'd40, -1, 0, 21);
    press(1'b0, 4'h9, 16'd3, -1, 0, -1);

    for (int k = 0; k < 16; k++) begin
      press(1'b1, 4'(k), 16'd64, -1, 1, -1);
      chk("loopback_key", 32'({det_v, det}), 32'({1'b1, 4'(k)}));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
